// File: rtl/tqvp_mp_seq_accel.sv
// Multi-cycle byte-bus ALU peripheral: single-cycle logic/add/shift ops, iterative shift-add MUL.
// Optional restoring divider (op 8) is built when TQVP_MP_ACCEL_DIV_EN is defined.
module tqvp_mp_seq_accel #(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] a_reg, b_reg, wa, wb, mplier;
    logic [3:0]        op_reg, wop;
    logic [RES_W-1:0]  result, acc, mcand, partial, single_res;
    logic [CNT_W-1:0]  count;
    logic [DATA_W:0]   sum, diff;
    logic              err, busy, done, illegal, is_multi, last_step;
    logic              ctl_wr, abort_cmd, start_cmd, accept;
    logic [15:0]       a_wide, b_wide;
    logic [31:0]       res_wide;
    logic              unused_ok;

    // Handshake: a host write is a single-cycle data_write pulse with address/data_in valid;
    // no back-pressure exists, so commands that arrive while BUSY are simply dropped.
    assign ctl_wr    = data_write && (address == 4'h5);
    assign abort_cmd = ctl_wr && data_in[1];
    assign start_cmd = ctl_wr && data_in[0] && !data_in[1];
    assign accept    = start_cmd && (state != BUSY);

    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign uo_out = {4'b0, err, done, busy, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start_cmd) state_next = BUSY;
            BUSY:       if (last_step) state_next = DONE;
            default:    state_next = IDLE;
        endcase
        if (abort_cmd) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
        end else if (data_write) begin
            case (address)
                4'h0: a_reg[7:0] <= data_in;
                4'h1: if (DATA_W == 16) a_reg[DATA_W-1 -: 8] <= data_in;
                4'h2: b_reg[7:0] <= data_in;
                4'h3: if (DATA_W == 16) b_reg[DATA_W-1 -: 8] <= data_in;
                4'h4: op_reg <= data_in[3:0];
                default: ;
            endcase
        end
    end

    assign sum  = {1'b0, wa} + {1'b0, wb};
    assign diff = {1'b0, wa} - {1'b0, wb};

    always_comb begin
        single_res = '0;
        illegal    = 1'b0;
        case (wop)
            4'd0: single_res = {{(DATA_W-1){1'b0}}, sum};
            4'd1: single_res = {{(DATA_W-1){1'b0}}, diff};
            4'd2: single_res = {{DATA_W{1'b0}}, wa & wb};
            4'd3: single_res = {{DATA_W{1'b0}}, wa | wb};
            4'd4: single_res = {{DATA_W{1'b0}}, wa ^ wb};
            4'd5: single_res = {{DATA_W{1'b0}}, wa << wb[CNT_W-1:0]};
            4'd6: single_res = {{DATA_W{1'b0}}, wa >> wb[CNT_W-1:0]};
            4'd7: ;
`ifdef TQVP_MP_ACCEL_DIV_EN
            4'd8: ;
`endif
            default: illegal = 1'b1;
        endcase
    end

    assign partial = acc + (mplier[0] ? mcand : '0);

`ifdef TQVP_MP_ACCEL_DIV_EN
    // Restoring divide: acc low half is the partial remainder, mplier shifts dividend out / quotient in.
    logic [DATA_W:0]   rem_shift, rem_sub;
    logic [DATA_W-1:0] rem_next, quot_next;
    logic              div_ge;
    always_comb begin
        rem_shift = {acc[DATA_W-1:0], mplier[DATA_W-1]};
        div_ge    = (rem_shift >= {1'b0, wb});
        rem_sub   = rem_shift - {1'b0, wb};
        rem_next  = div_ge ? rem_sub[DATA_W-1:0] : rem_shift[DATA_W-1:0];
        quot_next = {mplier[DATA_W-2:0], div_ge};
    end
    assign unused_ok = &{1'b0, ui_in, rem_sub[DATA_W], rem_shift[DATA_W]};
`else
    assign unused_ok = &{1'b0, ui_in};
`endif

    always_comb begin
        is_multi = (wop == 4'd7);
`ifdef TQVP_MP_ACCEL_DIV_EN
        if ((wop == 4'd8) && (wb != '0)) is_multi = 1'b1;
`endif
        last_step = !is_multi || (count == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa     <= '0;
            wb     <= '0;
            wop    <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (abort_cmd) begin
            err <= 1'b0;
        end else if (accept) begin
            wa     <= a_reg;
            wb     <= b_reg;
            wop    <= op_reg;
            mplier <= b_reg;
`ifdef TQVP_MP_ACCEL_DIV_EN
            if (op_reg == 4'd8) mplier <= a_reg;
`endif
            mcand  <= {{DATA_W{1'b0}}, a_reg};
            acc    <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (state == BUSY) begin
            if (wop == 4'd7) begin
                acc    <= partial;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (last_step) result <= partial;
            end
`ifdef TQVP_MP_ACCEL_DIV_EN
            else if (wop == 4'd8) begin
                if (wb == '0) begin
                    result <= {wa, {DATA_W{1'b1}}};
                    err    <= 1'b1;
                end else begin
                    acc    <= {{DATA_W{1'b0}}, rem_next};
                    mplier <= quot_next;
                    count  <= count + 1'b1;
                    if (last_step) result <= {rem_next, quot_next};
                end
            end
`endif
            else if (illegal) err <= 1'b1;
            else result <= single_res;
        end
    end

    assign a_wide   = 16'(a_reg);
    assign b_wide   = 16'(b_reg);
    assign res_wide = 32'(result);

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0: data_out = a_wide[7:0];
            4'h1: data_out = a_wide[15:8];
            4'h2: data_out = b_wide[7:0];
            4'h3: data_out = b_wide[15:8];
            4'h4: data_out = {4'b0, op_reg};
            4'h5: data_out = {5'b0, err, done, busy};
            4'h8: data_out = res_wide[7:0];
            4'h9: data_out = res_wide[15:8];
            4'hA: data_out = res_wide[23:16];
            4'hB: data_out = res_wide[31:24];
            default: data_out = 8'h00;
        endcase
    end
endmodule
